// File: rtl/counter_updown_param.sv
// -----------------------------------------------------------------------------
// counter_updown_param
//   Parameterised up/down counter over the range 0..MODULUS-1. It can either
//   wrap at the range ends or saturate there. A one-cycle carry or borrow
//   pulse marks every attempt to step past either end.
//
// Parameters
//   WIDTH    : counter width in bits (2..32)
//   MODULUS  : number of count positions (2..2^WIDTH)
//   SATURATE : 0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   reset      : asynchronous active-low reset
//   en         : count enable, one step per enabled edge
//   dir        : 1 = count up, 0 = count down
//   clr        : synchronous clear to 0 (highest priority)
//   load       : synchronous load of load_val, clamped to MODULUS-1
//   load_val   : value to load
//   ovf_clr    : synchronous clear of ovf_sticky
//   count      : registered counter value
//   tc         : terminal count for the current direction (combinational)
//   carry      : registered pulse on an up-overflow attempt
//   borrow     : registered pulse on a down-underflow attempt
//   ovf_sticky : sticky overflow/underflow flag
//
// Build option
//   COUNTER_UPDOWN_STICKY_EN : when defined, ovf_sticky is a real register.
//   It sets on any carry/borrow and clears on ovf_clr; a set wins over a
//   clear on the same edge. When undefined, ovf_sticky is tied to 0 and
//   ovf_clr is ignored.
// -----------------------------------------------------------------------------
module counter_updown_param #(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter int     SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry,
  output logic             borrow,
  output logic             ovf_sticky
);

  // Highest legal count value. When MODULUS = 2^WIDTH this is all ones, so
  // the wrap becomes a natural binary rollover.
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;

  // Step and compare in WIDTH+1 bits so that neither the increment nor the
  // load clamp can alias when WIDTH is already fully used by MODULUS.
  logic [WIDTH:0] up_w;
  logic [WIDTH:0] dn_w;
  logic           load_over;
  logic           at_top;
  logic           at_zero;
  logic           unused_msb;

  assign up_w      = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
  assign dn_w      = {1'b0, count_q} - {{WIDTH{1'b0}}, 1'b1};
  assign load_over = {1'b0, load_val} > {1'b0, TOP};
  assign at_top    = (count_q == TOP);
  assign at_zero   = (count_q == '0);
  // The boundary cases are decoded from at_top/at_zero, so the carry-out bit
  // of each step is never needed.
  assign unused_msb = up_w[WIDTH] ^ dn_w[WIDTH];

  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_over ? TOP : load_val;
    end else if (en) begin
      if (dir) begin
        if (at_top) begin
          carry_d = 1'b1;
          if (SATURATE == 0) count_d = '0;
        end else begin
          count_d = up_w[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
          borrow_d = 1'b1;
          if (SATURATE == 0) count_d = TOP;
        end else begin
          count_d = dn_w[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign count  = count_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;
  // Terminal count follows the live dir input, so it reflects the boundary
  // that the next enabled edge would hit.
  assign tc     = dir ? at_top : at_zero;

`ifdef COUNTER_UPDOWN_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (carry_d || borrow_d) begin
      sticky_d = 1'b1;
    end else if (ovf_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_counter_updown_param.sv
// -----------------------------------------------------------------------------
// tb_counter_updown_param
//   Bench for counter_updown_param. Four instances with different
//   WIDTH/MODULUS/SATURATE share one set of inputs:
//     u0 : 8 bit, modulus 256, wrap
//     u1 : 4 bit, modulus 10,  wrap
//     u2 : 4 bit, modulus 10,  saturate
//     u3 : 8 bit, modulus 100, wrap
//   An integer reference model tracks every instance and is compared after
//   each edge. Directed tables and sequences cover the boundary cases.
// -----------------------------------------------------------------------------
module tb_counter_updown_param;

  localparam int N = 4;

`ifdef COUNTER_UPDOWN_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       en, dir, clr, load, ovf_clr;
  logic [7:0] lv;

  logic [7:0]   c0, c3;
  logic [3:0]   c1, c2;
  logic [N-1:0] tc_v, car_v, bor_v, stk_v;

  int total = 0;
  int bad   = 0;

  int mods [N] = '{256, 10, 10, 100};
  int sats [N] = '{0, 0, 1, 0};
  int wids [N] = '{8, 4, 4, 8};

  int m_cnt [N];
  int m_car [N];
  int m_bor [N];
  int m_stk [N];

  always #5 clk = ~clk;

  counter_updown_param #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) u0 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lv), .ovf_clr(ovf_clr), .count(c0), .tc(tc_v[0]),
    .carry(car_v[0]), .borrow(bor_v[0]), .ovf_sticky(stk_v[0]));

  counter_updown_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u1 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lv[3:0]), .ovf_clr(ovf_clr), .count(c1), .tc(tc_v[1]),
    .carry(car_v[1]), .borrow(bor_v[1]), .ovf_sticky(stk_v[1]));

  counter_updown_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u2 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lv[3:0]), .ovf_clr(ovf_clr), .count(c2), .tc(tc_v[2]),
    .carry(car_v[2]), .borrow(bor_v[2]), .ovf_sticky(stk_v[2]));

  counter_updown_param #(.WIDTH(8), .MODULUS(100), .SATURATE(0)) u3 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lv), .ovf_clr(ovf_clr), .count(c3), .tc(tc_v[3]),
    .carry(car_v[3]), .borrow(bor_v[3]), .ovf_sticky(stk_v[3]));

  function automatic logic [63:0] act_cnt(input int k);
    case (k)
      0:       return 64'(c0);
      1:       return 64'(c1);
      2:       return 64'(c2);
      default: return 64'(c3);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    for (int k = 0; k < N; k++) begin
      m_cnt[k] = 0; m_car[k] = 0; m_bor[k] = 0; m_stk[k] = 0;
    end
  endtask

  // Reference behaviour of one rising edge, in plain integer arithmetic.
  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      int top = mods[k] - 1;
      int v   = int'(lv) % (1 << wids[k]);
      m_car[k] = 0;
      m_bor[k] = 0;
      if (clr) m_cnt[k] = 0;
      else if (load) m_cnt[k] = (v > top) ? top : v;
      else if (en) begin
        if (dir) begin
          if (m_cnt[k] == top) begin
            m_car[k] = 1;
            if (sats[k] == 0) m_cnt[k] = 0;
          end else m_cnt[k] = m_cnt[k] + 1;
        end else begin
          if (m_cnt[k] == 0) begin
            m_bor[k] = 1;
            if (sats[k] == 0) m_cnt[k] = top;
          end else m_cnt[k] = m_cnt[k] - 1;
        end
      end
      if (STK) begin
        if (m_car[k] != 0 || m_bor[k] != 0) m_stk[k] = 1;
        else if (ovf_clr) m_stk[k] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < N; k++) begin
      bit exp_tc;
      exp_tc = (dir && m_cnt[k] == mods[k] - 1) || (!dir && m_cnt[k] == 0);
      chk($sformatf("%s.count%0d", tag, k), act_cnt(k), 64'(m_cnt[k]));
      chk($sformatf("%s.carry%0d", tag, k), 64'(car_v[k]), 64'(m_car[k]));
      chk($sformatf("%s.borrow%0d", tag, k), 64'(bor_v[k]), 64'(m_bor[k]));
      chk($sformatf("%s.tc%0d", tag, k), 64'(tc_v[k]), 64'(exp_tc));
      chk($sformatf("%s.sticky%0d", tag, k), 64'(stk_v[k]), 64'(m_stk[k]));
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    en = 1'b0; dir = 1'b0; clr = 1'b0; load = 1'b0; ovf_clr = 1'b0; lv = 8'd0;
  endtask

  typedef struct {
    bit       clr;
    bit       load;
    bit       en;
    bit       dir;
    bit [7:0] lv;
    int       exp_cnt;
    bit       exp_bor;
    bit       exp_tc;
  } vec_t;

  vec_t vt [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table for the modulus-10 wrapping instance (u1).
    vt[0] = '{0, 1, 0, 0, 8'd3,  3, 0, 0};
    vt[1] = '{0, 0, 1, 0, 8'd0,  2, 0, 0};
    vt[2] = '{0, 0, 1, 0, 8'd0,  1, 0, 0};
    vt[3] = '{0, 0, 1, 0, 8'd0,  0, 0, 1};
    vt[4] = '{0, 0, 1, 0, 8'd0,  9, 1, 0};
    vt[5] = '{0, 0, 1, 0, 8'd0,  8, 0, 0};
    vt[6] = '{0, 1, 0, 1, 8'd15, 9, 0, 1};
    vt[7] = '{1, 1, 1, 1, 8'd5,  0, 0, 0};

    idle_inputs();
    reset = 1'b0;
    model_zero();
    #12;
    check_all("reset");
    reset = 1'b1;

    // Straight up-count on the 256 instance, wrapping past 255.
    clr = 1'b1;
    tick("clr0");
    clr = 1'b0; en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 260; i++) begin
      tick("up260");
      chk("up260.count", 64'(c0), 64'((i + 1) % 256));
      chk("up260.carry", 64'(car_v[0]), 64'(i == 255));
    end

    // Table-driven vectors on u1.
    for (int i = 0; i < 8; i++) begin
      clr = vt[i].clr; load = vt[i].load; en = vt[i].en; dir = vt[i].dir; lv = vt[i].lv;
      tick("vec");
      chk($sformatf("vec%0d.count", i), 64'(c1), 64'(vt[i].exp_cnt));
      chk($sformatf("vec%0d.borrow", i), 64'(bor_v[1]), 64'(vt[i].exp_bor));
      chk($sformatf("vec%0d.tc", i), 64'(tc_v[1]), 64'(vt[i].exp_tc));
    end
    idle_inputs();

    // Saturating instance held at the top with en asserted.
    load = 1'b1; lv = 8'd8;
    tick("sat_load");
    chk("sat.load", 64'(c2), 64'd8);
    load = 1'b0; en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick("sat");
      chk("sat.count", 64'(c2), 64'd9);
      chk("sat.carry", 64'(car_v[2]), 64'(i > 0));
      chk("sat.tc", 64'(tc_v[2]), 64'd1);
    end
    idle_inputs();

    // Load clamp, clr over load, clr over a boundary step (u3, modulus 100).
    load = 1'b1; lv = 8'd200;
    tick("clamp");
    chk("clamp.count", 64'(c3), 64'd99);
    clr = 1'b1;
    tick("clr_load");
    chk("clr_load.count", 64'(c3), 64'd0);
    clr = 1'b0; lv = 8'd99;
    tick("load99");
    clr = 1'b1; load = 1'b0; en = 1'b1; dir = 1'b1;
    tick("clr_edge");
    chk("clr_edge.count", 64'(c3), 64'd0);
    chk("clr_edge.carry", 64'(car_v[3]), 64'd0);
    idle_inputs();

    // Sticky flag on u1: set by a wrap, survives, cleared, set wins over clear.
    load = 1'b1; lv = 8'd9;
    tick("stk_load");
    load = 1'b0; en = 1'b1; dir = 1'b1;
    tick("stk_wrap");
    chk("stk.wrap", 64'(stk_v[1]), 64'(STK));
    en = 1'b0;
    tick("stk_hold");
    chk("stk.hold", 64'(stk_v[1]), 64'(STK));
    chk("stk.carry_drop", 64'(car_v[1]), 64'd0);
    ovf_clr = 1'b1;
    tick("stk_clr");
    chk("stk.clr", 64'(stk_v[1]), 64'd0);
    ovf_clr = 1'b0; load = 1'b1; lv = 8'd9;
    tick("stk_load2");
    load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
    tick("stk_race");
    chk("stk.race", 64'(stk_v[1]), 64'(STK));
    idle_inputs();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      clr     = ($urandom_range(0, 15) == 0);
      load    = ($urandom_range(0, 7) == 0);
      en      = ($urandom_range(0, 3) != 0);
      dir     = 1'($urandom_range(0, 1));
      ovf_clr = ($urandom_range(0, 7) == 0);
      lv      = 8'($urandom_range(0, 255));
      tick("rand");
    end
    idle_inputs();

    // Asynchronous reset between clock edges.
    en = 1'b1; dir = 1'b1;
    tick("pre_rst");
    tick("pre_rst");
    #3;
    reset = 1'b0;
    model_zero();
    #1;
    chk("arst.count0", 64'(c0), 64'd0);
    chk("arst.carry", 64'(car_v), 64'd0);
    chk("arst.borrow", 64'(bor_v), 64'd0);
    chk("arst.sticky", 64'(stk_v), 64'd0);
    check_all("arst");
    #2;
    reset = 1'b1;
    tick("post_rst");
    chk("post_rst.count0", 64'(c0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
